led_trail_gen: RTL and testbench

//   Parametrised LED trail generator: a lit "head" steps across NUM_LEDS outputs
//   at a programmable rate, leaving a PWM-faded tail behind it. Supports wrap and

---
 rtl/led_trail_gen.sv | 124 ++++++++++++
 tb/tb_led_trail_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_trail_gen.sv
// LED trail generator: a lit head steps across NUM_LEDS outputs at a programmable
// rate and leaves a PWM-faded tail behind it, in either wrap or bounce mode.
module led_trail_gen #(
   parameter  int NUM_LEDS  = 12,
   parameter  int PWM_BITS  = 4,
   parameter  int TRAIL_LEN = 4,
   parameter  int STEP_DIV  = 2500000,
   localparam int HW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                en,
   input  logic                mode,
   output logic [NUM_LEDS-1:0] led,
   output logic [HW-1:0]       head,
   output logic                dir,
   output logic                step
);

   localparam int MAX   = 2**PWM_BITS - 1;
   localparam int DECAY = MAX / TRAIL_LEN;
   localparam int PRW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PWM_BITS-1:0] MAX_V     = PWM_BITS'(MAX);
   localparam logic [PWM_BITS-1:0] DECAY_V   = PWM_BITS'(DECAY);
   localparam logic [HW-1:0]       LAST_IDX  = HW'(NUM_LEDS - 1);
   localparam logic [PRW-1:0]      PRESC_TOP = PRW'(STEP_DIV - 1);

   logic [PRW-1:0]      presc_q, presc_d;
   logic                tick;
   logic                tick_q;
   logic                step_q;
   logic [HW-1:0]       head_q, head_d;
   logic                dir_q, dir_d;
   logic [PWM_BITS-1:0] pwm_q;
   logic [PWM_BITS-1:0] bright_q [NUM_LEDS];
   logic [PWM_BITS-1:0] bright_d [NUM_LEDS];
   logic [NUM_LEDS-1:0] led_q, led_d;

   assign tick = en && (presc_q == PRESC_TOP);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      presc_d = presc_q;
      if (en) begin
         presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + 1'b1;
      end
   end

   // Head movement: wrap always runs upward; bounce reverses at either end without dwelling.
   always_comb begin
      head_d = head_q;
      dir_d  = dir_q;
      if (tick) begin
         if (NUM_LEDS == 1) begin
            head_d = '0;
            dir_d  = 1'b0;
         end else if (!mode) begin
            dir_d  = 1'b0;
            head_d = (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
         end else if (!dir_q) begin
            if (head_q == LAST_IDX) begin
               dir_d  = 1'b1;
               head_d = head_q - 1'b1;
            end else begin
               head_d = head_q + 1'b1;
            end
         end else begin
            if (head_q == '0) begin
               dir_d  = 1'b0;
               head_d = HW'(1);
            end else begin
               head_d = head_q - 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LEDS; i++) begin
         bright_d[i] = bright_q[i];
         if (tick) begin
            if (HW'(i) == head_d) begin
               bright_d[i] = MAX_V;
            end else begin
               bright_d[i] = (bright_q[i] > DECAY_V) ? bright_q[i] - DECAY_V : '0;
            end
         end
         led_d[i] = (bright_q[i] == MAX_V) | (pwm_q < bright_q[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         step_q  <= 1'b0;
         head_q  <= '0;
         dir_q   <= 1'b0;
         pwm_q   <= '0;
         led_q   <= '0;
         // NOTE: the brightness array is pattern state, not scratch storage, so it is reset like any register.
         for (int i = 0; i < NUM_LEDS; i++) begin
            bright_q[i] <= (i == 0) ? MAX_V : '0;
         end
      end else begin
         presc_q  <= presc_d;
         tick_q   <= tick;
         step_q   <= tick_q;
         head_q   <= head_d;
         dir_q    <= dir_d;
         pwm_q    <= pwm_q + 1'b1;
         led_q    <= led_d;
         bright_q <= bright_d;
      end
   end

   assign led  = led_q;
   assign head = head_q;
   assign dir  = dir_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_trail_gen.sv
// Directed bench for led_trail_gen with a small configuration: 5 LEDs, 16-level PWM,
// decay of 3 per step and a head step every 4 clocks.
module tb_led_trail_gen;

   logic       clk = 1'b0;
   logic       resetn;
   logic       en;
   logic       mode;
   logic [4:0] led;
   logic [2:0] head;
   logic       dir;
   logic       step;

   int n_total = 0;
   int n_pass  = 0;

   led_trail_gen #(
      .NUM_LEDS (5),
      .PWM_BITS (4),
      .TRAIL_LEN(4),
      .STEP_DIV (4)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .en    (en),
      .mode  (mode),
      .led   (led),
      .head  (head),
      .dir   (dir),
      .step  (step)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
         $error("check %s", tag);
      end
   endtask

   // One head step: pulse from the previous step on the first sampled cycle, low on the
   // second, and the new head visible on the fourth.
   task automatic do_step(input int h, input int d, input int s1);
      @(negedge clk); chk($sformatf("step_pulse_before_h%0d", h), step, s1);
      @(negedge clk); chk($sformatf("step_low_before_h%0d", h), step, 0);
      @(negedge clk);
      @(negedge clk);
      chk("head", head, h);
      chk("dir", dir, d);
   endtask

   // Counts on-cycles per LED over one full 16-cycle PWM period with the pattern frozen.
   task automatic measure_duty(input int e [5]);
      int cnt [5];
      for (int j = 0; j < 5; j++) cnt[j] = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         for (int j = 0; j < 5; j++) cnt[j] += int'(led[j]);
      end
      for (int j = 0; j < 5; j++) chk($sformatf("duty_led%0d", j), cnt[j], e[j]);
   endtask

   initial begin
      int bad_led;
      int bad_head;
      int bad_step;
      int bh [15];
      int bd [15];

      resetn = 1'b1;
      en     = 1'b0;
      mode   = 1'b0;
      #1 resetn = 1'b0;
      #1;
      chk("rst_led", led, 0);
      chk("rst_head", head, 0);
      chk("rst_dir", dir, 0);
      chk("rst_step", step, 0);

      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Released with en=0: head parked at 0, LED 0 solid on from the first edge.
      bad_led  = 0;
      bad_head = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (led !== 5'b00001) bad_led++;
         if (head !== 3'd0) bad_head++;
      end
      chk("idle_led_bad_cycles", bad_led, 0);
      chk("idle_head_bad_cycles", bad_head, 0);

      // Wrap mode, three steps, then freeze and check the fading tail.
      en = 1'b1;
      do_step(1, 0, 0);
      do_step(2, 0, 1);
      do_step(3, 0, 1);
      en = 1'b0;
      measure_duty('{6, 9, 12, 16, 0});
      chk("frozen_head", head, 3);

      en = 1'b1;
      do_step(4, 0, 0);
      @(negedge clk); chk("step_pulse_h4", step, 1);
      @(negedge clk);

      // Hold with the prescaler at 2: only the remaining two counts are needed afterwards.
      en       = 1'b0;
      bad_head = 0;
      bad_step = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (head !== 3'd4 || dir !== 1'b0) bad_head++;
         if (step !== 1'b0) bad_step++;
      end
      chk("hold_head_bad_cycles", bad_head, 0);
      chk("hold_step_bad_cycles", bad_step, 0);
      en = 1'b1;
      @(negedge clk); chk("resume_head_early", head, 4);
      @(negedge clk); chk("resume_head_wrap", head, 0);
      en = 1'b0;
      measure_duty('{16, 3, 6, 9, 12});

      // Bounce mode, then bounce->wrap while heading down.
      bh = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 0, 0};
      bd = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0};
      mode = 1'b1;
      en   = 1'b1;
      for (int s = 0; s < 13; s++) do_step(bh[s], bd[s], (s == 0) ? 0 : 1);
      mode = 1'b0;
      do_step(4, 0, 1);
      do_step(0, 0, 1);

      // Asynchronous reset between edges with head=3 and prescaler=2.
      do_step(1, 0, 1);
      do_step(2, 0, 1);
      do_step(3, 0, 1);
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_led3", led[3], 1);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_led", led, 0);
      chk("async_rst_head", head, 0);
      chk("async_rst_dir", dir, 0);
      chk("async_rst_step", step, 0);
      @(negedge clk);
      resetn = 1'b1;
      do_step(1, 0, 0);
      do_step(2, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
